// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
//   Multicycle fetch/execute controller for the Hack A/D/M register-memory
//   block. Every instruction takes three cycles: FETCH -> EXEC -> WRITE.
//   The sequencer latches the instruction from a combinational ROM, drives the
//   ALU control field and captures its result and flags. It then issues the
//   register-memory write enables for one cycle, evaluates the jump condition
//   and advances the program counter.
//
// Parameters
//   PC_WIDTH     program counter / ROM address width (at most 16)
//   RESET_PC     PC value loaded on reset
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   run          1 = execute, 0 = park in FETCH once the current instr retires
//   rom_addr     instruction address (the current pc)
//   rom_data     instruction word, valid in the same cycle as rom_addr
//   alu_out      ALU result
//   alu_zr       ALU result is zero
//   alu_ng       ALU result is negative
//   reg_a_out    current A register, used as the jump target
//   alu_ctrl     {zx,nx,zy,ny,f,no} taken from ir[11:6]
//   alu_sel_m    ALU y operand select (0 = A, 1 = M), taken from ir[12]
//   data_in      write data to the register-memory block
//   reg_a_en     A register write enable
//   reg_d_en     D register write enable
//   reg_m_en     M (memory) write enable
//   state        FSM state: 0 FETCH, 1 EXEC, 2 WRITE
//   instr_count  retired-instruction counter, wraps at 16 bits
// -----------------------------------------------------------------------------
module cpu_sequencer #(
  parameter int PC_WIDTH = 15,
  parameter int RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  output logic [PC_WIDTH-1:0] rom_addr,
  input  logic [15:0]         rom_data,
  input  logic [15:0]         alu_out,
  input  logic                alu_zr,
  input  logic                alu_ng,
  input  logic [15:0]         reg_a_out,
  output logic [5:0]          alu_ctrl,
  output logic                alu_sel_m,
  output logic [15:0]         data_in,
  output logic                reg_a_en,
  output logic                reg_d_en,
  output logic                reg_m_en,
  output logic [1:0]          state,
  output logic [15:0]         instr_count
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [PC_WIDTH-1:0] r_pc;
  logic [15:0]         r_ir;
  logic [15:0]         r_result;
  logic                r_zr_q;
  logic                r_ng_q;
  logic [15:0]         r_instr_count;

  // One-cycle strobes produced by the FSM decode.
  logic                w_ir_load;
  logic                w_exec;
  logic                w_retire;

  // Instruction field decode.
  logic                w_is_c;
  logic [2:0]          w_dest;
  logic [2:0]          w_jump;
  logic                w_taken;
  logic [PC_WIDTH-1:0] w_pc_nxt;

  // ir[14:13] are don't-care bits of a C-instruction; upper bits of A beyond
  // the PC width can never be jump targets.
  logic                w_unused;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Jump test on the flags captured in EXEC. The three jump bits select
  // "negative", "zero" and "positive"; any combination ORs together.
  function automatic logic f_jump_taken(
    input logic       is_c,
    input logic [2:0] jbits,
    input logic       zr,
    input logic       ng
  );
    logic pos;
    pos = ~zr & ~ng;
    return is_c & ((jbits[2] & ng) | (jbits[1] & zr) | (jbits[0] & pos));
  endfunction

  // Sequential PC step; wraps naturally from all-ones to zero.
  function automatic logic [PC_WIDTH-1:0] f_pc_inc(
    input logic [PC_WIDTH-1:0] pc
  );
    return pc + PC_WIDTH'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  assign w_is_c   = r_ir[15];
  assign w_dest   = r_ir[5:3];
  assign w_jump   = r_ir[2:0];
  assign w_taken  = f_jump_taken(w_is_c, w_jump, r_zr_q, r_ng_q);

  // reg_a_out is read before the register-memory block applies this cycle's
  // write, so a combined "jump + write A" instruction jumps to the old A.
  assign w_pc_nxt = w_taken ? reg_a_out[PC_WIDTH-1:0] : f_pc_inc(r_pc);

  assign w_unused = ^{r_ir[14:13], reg_a_out};

  // ---------------------------------------------------------------------------
  // FSM next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_ir_load   = 1'b0;
    w_exec      = 1'b0;
    w_retire    = 1'b0;
    alu_ctrl    = 6'd0;
    alu_sel_m   = 1'b0;
    data_in     = 16'd0;
    reg_a_en    = 1'b0;
    reg_d_en    = 1'b0;
    reg_m_en    = 1'b0;

    unique case (r_state)
      ST_FETCH: begin
        // run is only looked at here, so dropping it mid-instruction still
        // lets that instruction retire.
        if (run) begin
          w_ir_load   = 1'b1;
          w_state_nxt = ST_EXEC;
        end
      end

      ST_EXEC: begin
        alu_ctrl    = r_ir[11:6];
        alu_sel_m   = r_ir[12];
        w_exec      = 1'b1;
        w_state_nxt = ST_WRITE;
      end

      ST_WRITE: begin
        alu_ctrl    = r_ir[11:6];
        alu_sel_m   = r_ir[12];
        data_in     = r_result;
        // Enables depend on state and ir only, so an asynchronous reset
        // that forces FETCH removes them at once.
        if (w_is_c) begin
          reg_a_en = w_dest[2];
          reg_d_en = w_dest[1];
          reg_m_en = w_dest[0];
        end else begin
          reg_a_en = 1'b1;
        end
        w_retire    = 1'b1;
        w_state_nxt = ST_FETCH;
      end

      default: begin
        w_state_nxt = ST_FETCH;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FETCH -> EXEC: instruction register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ir <= 16'd0;
    end else if (w_ir_load) begin
      r_ir <= rom_data;
    end
  end

  // ---------------------------------------------------------------------------
  // EXEC -> WRITE: result and flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= 16'd0;
      r_zr_q   <= 1'b0;
      r_ng_q   <= 1'b0;
    end else if (w_exec) begin
      if (w_is_c) begin
        r_result <= alu_out;
        r_zr_q   <= alu_zr;
        r_ng_q   <= alu_ng;
      end else begin
        // A-instruction: the 15-bit constant is zero-extended and the
        // previous flags are left untouched (A-instructions never jump).
        r_result <= {1'b0, r_ir[14:0]};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // WRITE -> FETCH: program counter and retire counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= PC_WIDTH'(RESET_PC);
      r_instr_count <= 16'd0;
    end else if (w_retire) begin
      r_pc          <= w_pc_nxt;
      r_instr_count <= r_instr_count + 16'd1;
    end
  end

  assign rom_addr    = r_pc;
  assign state       = r_state;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_sequencer
//   Directed bench for cpu_sequencer. A behavioural combinational ROM feeds
//   instructions; the ALU and A register are driven directly by the bench.
//   Expected values are hand-computed from the Hack instruction encodings.
// -----------------------------------------------------------------------------
module tb_cpu_sequencer;

  localparam int PC_WIDTH = 15;

  logic                clk;
  logic                rst;
  logic                run;
  logic [PC_WIDTH-1:0] rom_addr;
  logic [15:0]         rom_data;
  logic [15:0]         alu_out;
  logic                alu_zr;
  logic                alu_ng;
  logic [15:0]         reg_a_out;
  logic [5:0]          alu_ctrl;
  logic                alu_sel_m;
  logic [15:0]         data_in;
  logic                reg_a_en;
  logic                reg_d_en;
  logic                reg_m_en;
  logic [1:0]          state;
  logic [15:0]         instr_count;

  logic [15:0] rom [0:(1<<PC_WIDTH)-1];

  int n_checks;
  int n_fail;

  assign rom_data = rom[rom_addr];

  cpu_sequencer #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .alu_out     (alu_out),
    .alu_zr      (alu_zr),
    .alu_ng      (alu_ng),
    .reg_a_out   (reg_a_out),
    .alu_ctrl    (alu_ctrl),
    .alu_sel_m   (alu_sel_m),
    .data_in     (data_in),
    .reg_a_en    (reg_a_en),
    .reg_d_en    (reg_d_en),
    .reg_m_en    (reg_m_en),
    .state       (state),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] ens();
    return {reg_a_en, reg_d_en, reg_m_en};
  endfunction

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    run       = 1'b0;
    alu_out   = 16'd0;
    alu_zr    = 1'b0;
    alu_ng    = 1'b0;
    reg_a_out = 16'd0;
    for (int i = 0; i < (1 << PC_WIDTH); i++) rom[i] = 16'h0000;
    rom[15'h0000] = 16'h1234;  // @0x1234
    rom[15'h0001] = 16'hEC10;  // D=A
    rom[15'h0002] = 16'hEC38;  // AMD=A
    rom[15'h0003] = 16'hEA87;  // 0;JMP
    rom[15'h0040] = 16'hE302;  // D;JEQ (not taken)
    rom[15'h0041] = 16'hE302;  // D;JEQ (taken)
    rom[15'h7FFF] = 16'h0007;  // A-instr with low bits set: must not jump

    // Reset state
    #3;
    chk("rst_state", state, 0);
    chk("rst_pc", rom_addr, 0);
    chk("rst_cnt", instr_count, 0);
    chk("rst_en", ens(), 3'b000);
    chk("rst_ctrl", {alu_sel_m, alu_ctrl}, 0);
    chk("rst_data", data_in, 0);

    @(posedge clk);
    #1;
    rst = 1'b0;
    run = 1'b1;

    // @0x1234
    step();
    chk("a_exec_state", state, 1);
    chk("a_exec_ctrl", alu_ctrl, 6'b001000);
    chk("a_exec_selm", alu_sel_m, 1);
    chk("a_exec_en", ens(), 3'b000);
    step();
    chk("a_wr_state", state, 2);
    chk("a_wr_en", ens(), 3'b100);
    chk("a_wr_data", data_in, 16'h1234);
    step();
    chk("a_ret_state", state, 0);
    chk("a_ret_pc", rom_addr, 1);
    chk("a_ret_cnt", instr_count, 1);
    chk("a_ret_en", ens(), 3'b000);
    chk("a_ret_ctrl", alu_ctrl, 0);

    // D=A with ALU stub 0x0055
    alu_out = 16'h0055;
    step();
    chk("dA_exec_ctrl", alu_ctrl, 6'b110000);
    chk("dA_exec_selm", alu_sel_m, 0);
    step();
    chk("dA_wr_en", ens(), 3'b010);
    chk("dA_wr_data", data_in, 16'h0055);
    step();
    chk("dA_ret_pc", rom_addr, 2);
    chk("dA_ret_cnt", instr_count, 2);

    // AMD=A: all three enables in one cycle only
    alu_out = 16'h0777;
    step();
    step();
    chk("amd_wr_en", ens(), 3'b111);
    chk("amd_wr_data", data_in, 16'h0777);
    step();
    chk("amd_ret_en", ens(), 3'b000);
    chk("amd_ret_pc", rom_addr, 3);
    chk("amd_ret_cnt", instr_count, 3);

    // 0;JMP to A=0x0040
    reg_a_out = 16'h0040;
    alu_out   = 16'h0000;
    alu_zr    = 1'b1;
    step();
    step();
    chk("jmp_wr_en", ens(), 3'b000);
    step();
    chk("jmp_pc", rom_addr, 15'h0040);
    chk("jmp_cnt", instr_count, 4);

    // D;JEQ with zr=0 -> fall through
    alu_out   = 16'h0005;
    alu_zr    = 1'b0;
    reg_a_out = 16'h0100;
    step();
    step();
    step();
    chk("jeq_nt_pc", rom_addr, 15'h0041);

    // D;JEQ with zr=1 -> jump to A=0x7FFF
    alu_out   = 16'h0000;
    alu_zr    = 1'b1;
    reg_a_out = 16'h7FFF;
    step();
    step();
    step();
    chk("jeq_t_pc", rom_addr, 15'h7FFF);
    chk("jeq_t_cnt", instr_count, 6);

    // A-instr at 0x7FFF: no jump despite stale zr, pc wraps to 0.
    // run drops during EXEC; the instruction must still retire.
    reg_a_out = 16'h1111;
    step();
    run = 1'b0;
    step();
    chk("wrap_wr_en", ens(), 3'b100);
    chk("wrap_wr_data", data_in, 16'h0007);
    step();
    chk("wrap_pc", rom_addr, 0);
    chk("wrap_state", state, 0);
    chk("wrap_cnt", instr_count, 7);

    // Parked with run=0
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_state", state, 0);
      chk("hold_en", ens(), 3'b000);
    end
    chk("hold_cnt", instr_count, 7);
    chk("hold_pc", rom_addr, 0);

    // A;JMP with dest A: pc takes old A, A takes the result
    rom[15'h0000] = 16'hEC27;
    rom[15'h0200] = 16'hEC38;
    alu_out   = 16'h0123;
    alu_zr    = 1'b0;
    alu_ng    = 1'b0;
    reg_a_out = 16'h0200;
    run       = 1'b1;
    step();
    chk("ja_exec_state", state, 1);
    step();
    chk("ja_wr_en", ens(), 3'b100);
    chk("ja_wr_data", data_in, 16'h0123);
    step();
    chk("ja_pc", rom_addr, 15'h0200);
    chk("ja_cnt", instr_count, 8);

    // Reset in WRITE of AMD=A kills the write immediately
    alu_out = 16'h0F0F;
    step();
    step();
    chk("kill_pre_en", ens(), 3'b111);
    #1;
    rst = 1'b1;
    #1;
    chk("kill_en", ens(), 3'b000);
    chk("kill_state", state, 0);
    chk("kill_pc", rom_addr, 0);
    chk("kill_cnt", instr_count, 0);
    chk("kill_data", data_in, 0);
    step();
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
